// File: rtl/dram_load_sequencer_if.sv
// Bus bundle for the DRAM load sequencer: chunk stream from the CDC FIFO and
// the MIG-style application write interface.
interface dram_load_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 27
);
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = 16;

  logic                  chunk_axis_tvalid;
  logic                  chunk_axis_tready;
  logic [DATA_W-1:0]     chunk_axis_tdata;
  logic                  chunk_axis_tlast;

  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [MASK_W-1:0]     app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;

  // Sequencer view: consumes the chunk stream, drives the app interface.
  modport master (
    input  chunk_axis_tvalid, chunk_axis_tdata, chunk_axis_tlast,
    output chunk_axis_tready,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
    output app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy
  );

  // Environment view: FIFO receiver and memory controller.
  modport slave (
    output chunk_axis_tvalid, chunk_axis_tdata, chunk_axis_tlast,
    input  chunk_axis_tready,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
    input  app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/dram_load_sequencer.sv
// Writes each 128-bit chunk from the CDC FIFO to consecutive DRAM addresses
// through the MIG app interface and flags when the tlast chunk is resident.
module dram_load_sequencer #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_STEP  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  dram_load_sequencer_if.master bus,
  output logic [23:0]           chunks_written,
  output logic                  load_done
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned CNT_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  data_done_q, data_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic                  take_c;

  // Calibration only gates new chunks; an in-flight chunk always finishes.
  assign take_c = (state_q == IDLE) && init_calib_complete && bus.chunk_axis_tvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      addr_q      <= ADDR_WIDTH'(BASE_ADDR);
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          hold_data_d = bus.chunk_axis_tdata;
          hold_last_d = bus.chunk_axis_tlast;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        // Command and data channels retire independently; finish once both have.
        cmd_done_d  = cmd_done_q  | bus.app_rdy;
        data_done_d = data_done_q | bus.app_wdf_rdy;
        if (cmd_done_d && data_done_d) begin
          addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = hold_last_q ? DONE : IDLE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // All app-side outputs decode from registered state only.
  assign bus.chunk_axis_tready = (state_q == IDLE) && init_calib_complete;
  assign bus.app_addr          = addr_q;
  assign bus.app_cmd           = 3'b000;
  assign bus.app_en            = (state_q == WRITE) && !cmd_done_q;
  assign bus.app_wdf_data      = hold_data_q;
  assign bus.app_wdf_mask      = MASK_W'(0);
  assign bus.app_wdf_wren      = (state_q == WRITE) && !data_done_q;
  assign bus.app_wdf_end       = bus.app_wdf_wren;
  assign chunks_written        = cnt_q;
  assign load_done             = (state_q == DONE);

endmodule

// File: tb/tb_dram_load_sequencer.sv
// Bench for dram_load_sequencer: a default DUT plus a narrow-address DUT run in
// lockstep, checked against a queue-based model of the expected DRAM writes.
module tb_dram_load_sequencer;

  localparam int unsigned W1 = 27, B1 = 0, S1 = 8;
  localparam int unsigned W2 = 4,  B2 = 8, S2 = 8;

  logic clk, rst, calib;
  logic [23:0] cw1, cw2;
  logic ld1, ld2;
  bit rand_rdy;
  int errors, checks;
  int en_cycles, wren_cycles;

  logic [W1-1:0] cmd_q[$];
  logic [W2-1:0] cmd2_q[$];
  logic [127:0]  dat_q[$];
  logic [127:0]  acc_q[$];
  logic [127:0]  exp_data[$];

  dram_load_sequencer_if #(.ADDR_WIDTH(W1)) bus ();
  dram_load_sequencer_if #(.ADDR_WIDTH(W2)) bus2 ();

  dram_load_sequencer #(.ADDR_WIDTH(W1), .BASE_ADDR(B1), .ADDR_STEP(S1)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib), .bus(bus),
    .chunks_written(cw1), .load_done(ld1));

  dram_load_sequencer #(.ADDR_WIDTH(W2), .BASE_ADDR(B2), .ADDR_STEP(S2)) dut2 (
    .clk(clk), .rst(rst), .init_calib_complete(calib), .bus(bus2),
    .chunks_written(cw2), .load_done(ld2));

  assign bus2.chunk_axis_tvalid = bus.chunk_axis_tvalid;
  assign bus2.chunk_axis_tdata  = bus.chunk_axis_tdata;
  assign bus2.chunk_axis_tlast  = bus.chunk_axis_tlast;
  assign bus2.app_rdy           = bus.app_rdy;
  assign bus2.app_wdf_rdy       = bus.app_wdf_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every accepted transfer; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.app_en && bus.app_rdy) cmd_q.push_back(bus.app_addr);
      if (bus2.app_en && bus2.app_rdy) cmd2_q.push_back(bus2.app_addr);
      if (bus.app_wdf_wren && bus.app_wdf_rdy) dat_q.push_back(bus.app_wdf_data);
      if (bus.chunk_axis_tvalid && bus.chunk_axis_tready) acc_q.push_back(bus.chunk_axis_tdata);
      if (bus.app_en) en_cycles++;
      if (bus.app_wdf_wren) wren_cycles++;
    end
  end

  function automatic logic [W1-1:0] model_addr(input int i);
    longint unsigned a;
    a = (longint'(B1) + longint'(i) * longint'(S1)) % (64'd1 << W1);
    return W1'(a);
  endfunction

  function automatic logic [W2-1:0] model_addr2(input int i);
    int unsigned a;
    a = (B2 + i * S2) % (32'd1 << W2);
    return W2'(a);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      bus.app_rdy     = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic clear_logs();
    cmd_q.delete(); cmd2_q.delete(); dat_q.delete(); acc_q.delete(); exp_data.delete();
    en_cycles = 0; wren_cycles = 0;
  endtask

  task automatic do_reset(input logic cal);
    #2 rst = 1'b0;
    calib = cal; rand_rdy = 0;
    bus.chunk_axis_tvalid = 1'b0; bus.chunk_axis_tlast = 1'b0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    repeat (2) step();
    @(negedge clk) rst = 1'b1;
    step();
    clear_logs();
  endtask

  // Present one chunk until accepted; then scramble tdata to prove it was captured.
  task automatic send_chunk(input logic [127:0] d, input logic last);
    bit ok = 0;
    bus.chunk_axis_tvalid = 1'b1; bus.chunk_axis_tdata = d; bus.chunk_axis_tlast = last;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.chunk_axis_tready) ok = 1;
      step();
    end
    bus.chunk_axis_tvalid = 1'b0; bus.chunk_axis_tdata = rnd128(); bus.chunk_axis_tlast = 1'($urandom);
    if (ok) exp_data.push_back(d);
    else begin checks++; errors++; $display("FAIL send_chunk: no handshake within 300 cycles"); end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!bus.app_en && !bus.app_wdf_wren) ok = 1;
      step();
    end
    if (!ok) begin checks++; errors++; $display("FAIL drain: app activity never stopped"); end
  endtask

  task automatic test_reset();
    rst = 1'b0; calib = 1'b0; rand_rdy = 0;
    bus.chunk_axis_tvalid = 1'b1; bus.chunk_axis_tdata = rnd128(); bus.chunk_axis_tlast = 1'b0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end} !== 3'b000) begin errors++; $display("FAIL reset_app: got %b required 000", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}); end
    checks++; if ({bus.chunk_axis_tready, ld1} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {bus.chunk_axis_tready, ld1}); end
    checks++; if (cw1 !== 24'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", cw1); end
    checks++; if (bus.app_addr !== model_addr(0)) begin errors++; $display("FAIL reset_addr: got %h required %h", bus.app_addr, model_addr(0)); end
    checks++; if (bus2.app_addr !== model_addr2(0)) begin errors++; $display("FAIL reset_addr2: got %h required %h", bus2.app_addr, model_addr2(0)); end
    checks++; if (bus.app_wdf_data !== 128'd0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.app_wdf_data); end
    bus.chunk_axis_tvalid = 1'b0;
    rst = 1'b1; calib = 1'b1;
    step();
    clear_logs();
    @(negedge clk);
    checks++; if (bus.chunk_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %b required 1", bus.chunk_axis_tready); end
    step();
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_reset(1'b1);
    send_chunk(d, 1'b1);
    @(negedge clk);
    checks++; if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.app_cmd} !== 6'b111000) begin errors++; $display("FAIL single_issue: en/wren/end/cmd got %b required 111000", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.app_cmd}); end
    checks++; if (bus.app_wdf_mask !== 16'h0) begin errors++; $display("FAIL single_mask: got %h required 0", bus.app_wdf_mask); end
    bus.chunk_axis_tvalid = 1'b1;
    repeat (5) step();
    @(negedge clk);
    checks++; if (cmd_q.size() != 1 || cmd_q[0] !== model_addr(0)) begin errors++; $display("FAIL single_addr: count %0d required 1 at %h", cmd_q.size(), model_addr(0)); end
    checks++; if (dat_q.size() != 1 || dat_q[0] !== d) begin errors++; $display("FAIL single_data: count %0d required 1 of %h", dat_q.size(), d); end
    checks++; if (en_cycles != 1 || wren_cycles != 1) begin errors++; $display("FAIL single_once: en %0d wren %0d cycles required 1 1", en_cycles, wren_cycles); end
    checks++; if ({ld1, cw1} !== {1'b1, 24'd1}) begin errors++; $display("FAIL single_done: load_done %b count %0d required 1 1", ld1, cw1); end
    checks++; if (bus.chunk_axis_tready !== 1'b0 || acc_q.size() != 1) begin errors++; $display("FAIL single_tready_hold: tready %b accepts %0d required 0 1", bus.chunk_axis_tready, acc_q.size()); end
    bus.chunk_axis_tvalid = 1'b0;
    step();
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) send_chunk(rnd128(), i == 3);
    @(negedge clk);
    checks++; if ({ld1, cw1} !== {1'b0, 24'd3}) begin errors++; $display("FAIL stream_before_last: load_done %b count %0d required 0 3", ld1, cw1); end
    step();
    @(negedge clk);
    checks++; if ({ld1, cw1} !== {1'b1, 24'd4}) begin errors++; $display("FAIL stream_after_last: load_done %b count %0d required 1 4", ld1, cw1); end
    checks++; if (cmd_q.size() != 4 || dat_q.size() != 4) begin errors++; $display("FAIL stream_counts: cmds %0d beats %0d required 4 4", cmd_q.size(), dat_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_q[i] !== model_addr(i) || dat_q[i] !== exp_data[i]) begin errors++; $display("FAIL stream_write%0d: addr %h data %h required %h %h", i, cmd_q[i], dat_q[i], model_addr(i), exp_data[i]); end
    end
    step();
  endtask

  task automatic test_independent();
    do_reset(1'b1);
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b1;
    send_chunk(rnd128(), 1'b0);
    @(negedge clk);
    checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b11) begin errors++; $display("FAIL indep_cmd_first_cycle: en/wren %b required 11", {bus.app_en, bus.app_wdf_wren}); end
    step(); step();
    @(negedge clk);
    checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b10) begin errors++; $display("FAIL indep_cmd_wait: en/wren %b required 10", {bus.app_en, bus.app_wdf_wren}); end
    step();
    bus.app_rdy = 1'b1;
    step();
    @(negedge clk);
    checks++; if (en_cycles != 4 || wren_cycles != 1 || bus.chunk_axis_tready !== 1'b1) begin errors++; $display("FAIL indep_cmd_late: en %0d wren %0d tready %b required 4 1 1", en_cycles, wren_cycles, bus.chunk_axis_tready); end
    step();
    en_cycles = 0; wren_cycles = 0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b0;
    send_chunk(rnd128(), 1'b0);
    step(); step();
    @(negedge clk);
    checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b01) begin errors++; $display("FAIL indep_data_wait: en/wren %b required 01", {bus.app_en, bus.app_wdf_wren}); end
    step();
    bus.app_wdf_rdy = 1'b1;
    step();
    @(negedge clk);
    checks++; if (en_cycles != 1 || wren_cycles != 4) begin errors++; $display("FAIL indep_data_late: en %0d wren %0d required 1 4", en_cycles, wren_cycles); end
    checks++; if (cmd_q.size() != 2 || dat_q.size() != 2) begin errors++; $display("FAIL indep_counts: cmds %0d beats %0d required 2 2", cmd_q.size(), dat_q.size()); end
    else begin
      checks++; if (cmd_q[1] !== model_addr(1) || dat_q[0] !== exp_data[0] || dat_q[1] !== exp_data[1]) begin errors++; $display("FAIL indep_writes: addr %h required %h", cmd_q[1], model_addr(1)); end
    end
    checks++; if ({ld1, cw1} !== {1'b0, 24'd2}) begin errors++; $display("FAIL indep_status: load_done %b count %0d required 0 2", ld1, cw1); end
    step();
  endtask

  task automatic test_random_stream();
    int n;
    bit done;
    n = 20; done = 0;
    do_reset(1'b1);
    rand_rdy = 1;
    for (int i = 0; i < n; i++) begin
      send_chunk(rnd128(), i == n - 1);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ld1) done = 1;
      step();
    end
    rand_rdy = 0;
    checks++; if (!done || cw1 !== 24'(n)) begin errors++; $display("FAIL rand_done: load_done %b count %0d required 1 %0d", ld1, cw1, n); end
    checks++; if (cmd_q.size() != n || dat_q.size() != n) begin errors++; $display("FAIL rand_counts: cmds %0d beats %0d required %0d", cmd_q.size(), dat_q.size(), n); end
    else for (int i = 0; i < n; i++) begin
      checks++; if (cmd_q[i] !== model_addr(i) || dat_q[i] !== exp_data[i]) begin errors++; $display("FAIL rand_write%0d: addr %h data %h required %h %h", i, cmd_q[i], dat_q[i], model_addr(i), exp_data[i]); end
    end
  endtask

  task automatic test_calib();
    do_reset(1'b0);
    bus.chunk_axis_tvalid = 1'b1; bus.chunk_axis_tdata = rnd128(); bus.chunk_axis_tlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({bus.chunk_axis_tready, bus.app_en, bus.app_wdf_wren} !== 3'b000) begin errors++; $display("FAIL calib_gate%0d: tready/en/wren %b required 000", i, {bus.chunk_axis_tready, bus.app_en, bus.app_wdf_wren}); end
      step();
    end
    calib = 1'b1;
    @(negedge clk);
    checks++; if (bus.chunk_axis_tready !== 1'b1) begin errors++; $display("FAIL calib_raise_tready: got %b required 1", bus.chunk_axis_tready); end
    step();
    bus.chunk_axis_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (acc_q.size() != 1 || bus.app_en !== 1'b1) begin errors++; $display("FAIL calib_handshake: accepts %0d en %b required 1 1", acc_q.size(), bus.app_en); end
    step();
    drain();
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) send_chunk(rnd128(), i == 2);
    drain();
    checks++; if (cmd2_q.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d required 3", cmd2_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (cmd2_q[i] !== model_addr2(i)) begin errors++; $display("FAIL wrap_addr%0d: got %h required %h", i, cmd2_q[i], model_addr2(i)); end
    end
    checks++; if ({ld2, cw2} !== {1'b1, 24'd3}) begin errors++; $display("FAIL wrap_status: load_done %b count %0d required 1 3", ld2, cw2); end
  endtask

  task automatic test_reset_mid_write();
    do_reset(1'b1);
    send_chunk(rnd128(), 1'b0);
    drain();
    bus.app_rdy = 1'b0;
    send_chunk(rnd128(), 1'b1);
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b00) begin errors++; $display("FAIL midreset_async: en/wren %b required 00", {bus.app_en, bus.app_wdf_wren}); end
    #10;
    @(negedge clk) rst = 1'b1;
    bus.app_rdy = 1'b1;
    step();
    @(negedge clk);
    checks++; if (bus.app_addr !== model_addr(0) || cw1 !== 24'd0) begin errors++; $display("FAIL midreset_state: addr %h count %0d required %h 0", bus.app_addr, cw1, model_addr(0)); end
    checks++; if ({ld1, bus.chunk_axis_tready} !== 2'b01) begin errors++; $display("FAIL midreset_flags: load_done/tready %b required 01", {ld1, bus.chunk_axis_tready}); end
    step();
  endtask

  initial begin
    errors = 0; checks = 0; rst = 1'b0; calib = 1'b0; rand_rdy = 0;
    test_reset();
    test_single();
    test_stream();
    test_independent();
    test_calib();
    test_wrap();
    test_random_stream();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
